sa_host_ctrl: RTL and testbench
===============================

SA_HOST_CTRL -- requirements
Module: sa_host_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 2, systolic array dimension; WIDTH, default 8, signed operand width; ACC, default 32, signed result width; SETTLE, default 2*N, cycles from sa_done to C capture; TIMEOUT, default 1024, maximum cycles to wait for sa_done.
REQ-002 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  operand stream valid
- s_ready  out  1  operand stream ready
- s_data  in  WIDTH  signed operand element
- m_valid  out  1  result stream valid
- m_ready  in  1  result stream ready
- m_data  out  ACC  signed result element
- m_last  out  1  marks final result element (C[N-1][N-1])
- sa_start  out  1  one-cycle start pulse to array core
- sa_done  in  1  array core completion
- A_mem  out  N x N x WIDTH  operand A to core
- B_mem  out  N x N x WIDTH  operand B to core
- C_in  in  N x N x ACC  result C from core
- busy  out  1  high in any state other than LOAD
- err_timeout  out  1  one-cycle pulse when sa_done is not seen within TIMEOUT

Function
REQ-004 The FSM SHALL have states LOAD, START, WAIT, SETTLE, DRAIN.
REQ-005 In LOAD, s_ready SHALL be 1 and each s_valid&s_ready handshake SHALL write s_data to the next element, in order A row-major (N*N elements), then B row-major (N*N elements).
REQ-006 Gaps in s_valid SHALL stall loading without loss or reordering.
REQ-007 On the handshake of element 2*N*N-1, the FSM SHALL enter START; sa_start SHALL be 1 for exactly the next cycle, then the FSM SHALL enter WAIT.
REQ-008 s_ready SHALL be 0 in every state except LOAD.
REQ-009 A_mem/B_mem SHALL be written only in LOAD and SHALL hold stable from START until the FSM returns to LOAD.
REQ-010 In WAIT, a cycle counter SHALL start at 0 on entry; sa_done=1 SHALL move the FSM to SETTLE.
REQ-011 If the counter reaches TIMEOUT-1 without sa_done, err_timeout SHALL pulse for 1 cycle and the FSM SHALL return to LOAD with the element index cleared.
REQ-012 SETTLE SHALL last exactly SETTLE cycles; on its last cycle all N*N words of C_in SHALL be captured into an internal buffer and the FSM SHALL enter DRAIN.
REQ-013 In DRAIN, m_valid SHALL be 1 and m_data SHALL present the buffered C row-major; the index SHALL advance only on m_valid&m_ready.
REQ-014 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-015 m_last SHALL be 1 only with C[N-1][N-1]; its handshake SHALL return the FSM to LOAD, and s_ready SHALL be 1 on the next cycle.
REQ-016 sa_done SHALL be ignored outside WAIT; C_in changes after capture SHALL not affect m_data.
REQ-017 Results SHALL pass unmodified (no truncation or saturation); operands SHALL pass as signed WIDTH bits.
REQ-018 Latency: with m_ready=1, the first m_valid SHALL occur SETTLE+1 cycles after the first cycle sa_done is sampled high.

Reset
REQ-019 While rst=1 on a clk edge, the FSM SHALL go to LOAD, all counters and indices SHALL clear, and A_mem, B_mem and the C buffer SHALL clear to 0.
REQ-020 While rst=1 on a clk edge, s_ready, m_valid, m_last, sa_start, busy and err_timeout SHALL be 0, and m_data SHALL be 0.
REQ-021 Reset asserted in any state, including mid-WAIT or mid-DRAIN, SHALL abort the transaction; no m_valid SHALL appear until a new full operand load completes.

Verification
REQ-022 Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]] with a core model -> m_data sequence 19, 22, 43, 50, with m_last only on 50, and exactly one sa_start pulse.
REQ-023 Signed operands: A=[[-4,4],[0,-1]], B=[[4,-4],[2,3]] -> m_data sequence -8, 28, -2, -3.
REQ-024 Stalls: random s_valid gaps plus m_ready held low for 5 cycles on element 1 -> element order unchanged, m_data stable during the stall, results same as REQ-022.
REQ-025 Timeout: sa_done held 0 -> err_timeout pulses exactly TIMEOUT cycles after WAIT entry, m_valid stays 0, and s_ready=1 on the following cycle.
REQ-026 Reset mid-WAIT: rst asserted for 1 cycle during WAIT, then sa_done pulses -> no m_valid; a fresh load then yields correct results.
REQ-027 Back-to-back: 10 random transactions with operands in [-4,4] -> every C matches the reference A*B.

Source files
------------

// File: rtl/sa_host_ctrl.sv
// sa_host_ctrl: streams A/B operands into a systolic array core, starts it,
// waits for completion, then streams the captured C matrix out row-major.
module sa_host_ctrl #(
    parameter int N       = 2,
    parameter int WIDTH   = 8,
    parameter int ACC     = 32,
    parameter int SETTLE  = 2*N,
    parameter int TIMEOUT = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [WIDTH-1:0]                    s_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [ACC-1:0]                      m_data,
    output logic                                m_last,
    output logic                                sa_start,
    input  logic                                sa_done,
    output logic [N-1:0][N-1:0][WIDTH-1:0]      A_mem,
    output logic [N-1:0][N-1:0][WIDTH-1:0]      B_mem,
    input  logic [N-1:0][N-1:0][ACC-1:0]        C_in,
    output logic                                busy,
    output logic                                err_timeout
);
    localparam int EW   = (N*N > 1) ? $clog2(N*N) : 1;
    localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [EW-1:0] E_LAST = EW'(N*N-1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT-1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE-1);

    typedef enum logic [2:0] {ST_LOAD, ST_START, ST_WAIT, ST_SETTLE, ST_DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [EW-1:0]            pos;
    logic                     sel_b;
    logic [CW-1:0]            cnt;
    logic [N*N-1:0][WIDTH-1:0] a_buf, b_buf;
    logic [N*N-1:0][ACC-1:0]  c_buf;
    logic                     err_q, timeout_hit, s_fire, m_fire;

    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        sa_start    = 1'b0;
        busy        = 1'b0;
        timeout_hit = 1'b0;
        s_fire      = 1'b0;
        m_fire      = 1'b0;
        if (!rst) begin
            busy = state != ST_LOAD;
            case (state)
                ST_LOAD: begin
                    s_ready = 1'b1;
                    s_fire  = s_valid;
                    if (s_valid && sel_b && pos == E_LAST) state_nxt = ST_START;
                end
                ST_START: begin
                    sa_start  = 1'b1;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (sa_done) state_nxt = ST_SETTLE;
                    else if (cnt == T_LAST) begin
                        timeout_hit = 1'b1;
                        state_nxt   = ST_LOAD;
                    end
                end
                ST_SETTLE: if (cnt == S_LAST) state_nxt = ST_DRAIN;
                ST_DRAIN: begin
                    m_valid = 1'b1;
                    m_fire  = m_ready;
                    if (m_ready && pos == E_LAST) state_nxt = ST_LOAD;
                end
                default: state_nxt = ST_LOAD;
            endcase
        end
    end

    // cnt restarts on every state change, so it measures time spent in WAIT/SETTLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
            pos   <= '0;
            sel_b <= 1'b0;
            cnt   <= '0;
            err_q <= 1'b0;
            a_buf <= '0;
            b_buf <= '0;
            c_buf <= '0;
        end else begin
            state <= state_nxt;
            err_q <= timeout_hit;
            cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
            if (s_fire) begin
                if (sel_b) b_buf[pos] <= s_data;
                else a_buf[pos] <= s_data;
                pos <= (pos == E_LAST) ? '0 : pos + 1'b1;
                if (pos == E_LAST) sel_b <= !sel_b;
            end
            if (m_fire) pos <= (pos == E_LAST) ? '0 : pos + 1'b1;
            if (timeout_hit) begin
                pos   <= '0;
                sel_b <= 1'b0;
            end
            if (state == ST_SETTLE && state_nxt == ST_DRAIN) c_buf <= C_in;
        end
    end

    assign A_mem       = a_buf;
    assign B_mem       = b_buf;
    assign m_data      = m_valid ? c_buf[pos] : '0;
    assign m_last      = m_valid && pos == E_LAST;
    assign err_timeout = err_q && !rst;
endmodule

// File: tb/tb_sa_host_ctrl.sv
// tb_sa_host_ctrl: randomized self-checking bench with a matrix-multiply core
// model and an A*B reference computed from the operands the bench sends.
module tb_sa_host_ctrl;
    localparam int N = 2, WIDTH = 8, ACC = 32, SETTLE = 2*N, TIMEOUT = 50, NN = N*N;

    logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, m_ready = 1'b1, sa_done = 1'b0;
    logic s_ready, m_valid, m_last, sa_start, busy, err_timeout;
    logic [WIDTH-1:0] s_data = '0;
    logic [ACC-1:0] m_data;
    logic [N-1:0][N-1:0][WIDTH-1:0] A_mem, B_mem;
    logic [N-1:0][N-1:0][ACC-1:0] C_in = '0;

    int checks = 0, failures = 0, cyc = 0, start_pulses = 0, done_cyc = 0;
    bit core_en = 1'b1;
    int core_delay = 3;
    int a_ref[N][N], b_ref[N][N];

    sa_host_ctrl #(.N(N), .WIDTH(WIDTH), .ACC(ACC), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .sa_start(sa_start), .sa_done(sa_done), .A_mem(A_mem), .B_mem(B_mem),
        .C_in(C_in), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sa_start) start_pulses <= start_pulses + 1;

    // Array core model: multiplies whatever the controller presents, then scrambles C after capture
    initial begin
        forever begin
            @(negedge clk);
            if (core_en && sa_start) begin
                repeat (core_delay) @(negedge clk);
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        int s;
                        s = 0;
                        for (int k = 0; k < N; k++)
                            s += int'($signed(A_mem[i][k])) * int'($signed(B_mem[k][j]));
                        C_in[i][j] = ACC'(s);
                    end
                sa_done  = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                sa_done = 1'b0;
                repeat (SETTLE) @(negedge clk);
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) C_in[i][j] = ACC'($urandom);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int exp_c(int i, int j);
        int s = 0;
        for (int k = 0; k < N; k++) s += a_ref[i][k] * b_ref[k][j];
        return s;
    endfunction

    function automatic bit mem_ok();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (A_mem[i][j] !== WIDTH'(a_ref[i][j]) || B_mem[i][j] !== WIDTH'(b_ref[i][j])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_ref[i][j] = int'($urandom_range(0, hi - lo)) + lo;
                b_ref[i][j] = int'($urandom_range(0, hi - lo)) + lo;
            end
    endtask

    task automatic send_ops(input bit gaps);
        int v, t;
        for (int e = 0; e < 2*NN; e++) begin
            v = (e < NN) ? a_ref[e/N][e%N] : b_ref[(e-NN)/N][(e-NN)%N];
            if (gaps) while ($urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = WIDTH'(v);
            t = 0;
            while (s_ready !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (s_ready !== 1'b1) begin
                failures++;
                $display("FAIL load_ready elem=%0d s_ready=%b expected 1", e, s_ready);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    // mode 0: m_ready always high; 1: 5-cycle stall on element 1; 2: random stalls
    task automatic drain_check(input string name, input int mode);
        int t, hold;
        logic [ACC-1:0] want;
        for (int e = 0; e < NN; e++) begin
            t = 0;
            while (m_valid !== 1'b1 && t < TIMEOUT + 100) begin
                @(negedge clk);
                t++;
            end
            want = ACC'(exp_c(e/N, e%N));
            checks++;
            if (m_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s no_m_valid elem=%0d got m_valid=%b expected 1", name, e, m_valid);
                m_ready = 1'b1;
                return;
            end
            if (e == 0) begin
                checks++;
                if (cyc - done_cyc !== SETTLE + 1) begin
                    failures++;
                    $display("FAIL %s latency got=%0d expected=%0d", name, cyc - done_cyc, SETTLE + 1);
                end
            end
            hold = (mode == 1) ? ((e == 1) ? 5 : 0) : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (hold > 0) m_ready = 1'b0;
            for (int h = 0; h <= hold; h++) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== want || m_last !== (e == NN - 1)) begin
                    failures++;
                    $display("FAIL %s elem=%0d hold=%0d got data=%0d last=%b valid=%b expected data=%0d last=%b",
                             name, e, h, $signed(m_data), m_last, m_valid, $signed(want), e == NN - 1);
                end
                if (h == hold) m_ready = 1'b1;
                @(negedge clk);
            end
        end
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s post_drain got m_valid=%b s_ready=%b busy=%b expected 0 1 0", name, m_valid, s_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_last, sa_start, busy, err_timeout} !== 6'b0 || m_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got flags=%b m_data=%0d expected 0", {s_ready, m_valid, m_last, sa_start, busy, err_timeout}, m_data);
        end
        checks++;
        if (A_mem !== '0 || B_mem !== '0) begin
            failures++;
            $display("FAIL reset_mem got A=%h B=%h expected 0", A_mem, B_mem);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got s_ready=%b busy=%b expected 1 0", s_ready, busy);
        end
    endtask

    task automatic test_basic();
        int p0;
        a_ref = '{'{1, 2}, '{3, 4}};
        b_ref = '{'{5, 6}, '{7, 8}};
        core_delay = 3;
        p0 = start_pulses;
        send_ops(1'b0);
        checks++;
        if (sa_start !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_state got sa_start=%b s_ready=%b busy=%b expected 1 0 1", sa_start, s_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (sa_start !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_pulse_width got sa_start=%b s_ready=%b expected 0 0", sa_start, s_ready);
        end
        checks++;
        if (!mem_ok()) begin
            failures++;
            $display("FAIL basic_mem got A=%h B=%h", A_mem, B_mem);
        end
        drain_check("basic", 0);
        checks++;
        if (start_pulses - p0 !== 1) begin
            failures++;
            $display("FAIL basic_start_count got=%0d expected=1", start_pulses - p0);
        end
        checks++;
        if (!mem_ok()) begin
            failures++;
            $display("FAIL basic_mem_hold got A=%h B=%h", A_mem, B_mem);
        end
    endtask

    task automatic test_signed();
        a_ref = '{'{-4, 4}, '{0, -1}};
        b_ref = '{'{4, -4}, '{2, 3}};
        send_ops(1'b0);
        drain_check("signed", 0);
        fill_rand(-128, 127);
        send_ops(1'b1);
        drain_check("full_range", 2);
    endtask

    task automatic test_stall();
        a_ref = '{'{1, 2}, '{3, 4}};
        b_ref = '{'{5, 6}, '{7, 8}};
        send_ops(1'b1);
        drain_check("stall", 1);
        checks++;
        if (!mem_ok()) begin
            failures++;
            $display("FAIL stall_mem got A=%h B=%h", A_mem, B_mem);
        end
    endtask

    task automatic test_timeout();
        int first = -1, pulses = 0;
        bit saw_valid = 1'b0;
        logic sr = 1'b0;
        core_en = 1'b0;
        fill_rand(-4, 4);
        send_ops(1'b0);
        for (int k = 1; k <= TIMEOUT + 5; k++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (m_valid !== 1'b0) saw_valid = 1'b1;
            if (k == TIMEOUT + 2) sr = s_ready;
        end
        checks++;
        if (first !== TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_when got=%0d expected=%0d", first, TIMEOUT + 1);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL timeout_width got=%0d expected=1", pulses);
        end
        checks++;
        if (saw_valid || sr !== 1'b1) begin
            failures++;
            $display("FAIL timeout_after got m_valid_seen=%b s_ready=%b expected 0 1", saw_valid, sr);
        end
        core_en = 1'b1;
    endtask

    task automatic test_reset_wait();
        bit saw = 1'b0;
        core_en = 1'b0;
        fill_rand(-4, 4);
        send_ops(1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL wait_state got busy=%b s_ready=%b expected 1 0", busy, s_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, busy, err_timeout} !== 4'b0 || A_mem !== '0 || B_mem !== '0) begin
            failures++;
            $display("FAIL reset_wait got flags=%b A=%h B=%h expected 0", {s_ready, m_valid, busy, err_timeout}, A_mem, B_mem);
        end
        rst = 1'b0;
        sa_done = 1'b1;
        @(negedge clk);
        sa_done = 1'b0;
        repeat (3*SETTLE + 10) begin
            @(negedge clk);
            if (m_valid !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL reset_wait_spurious got m_valid_seen=1 expected 0");
        end
        core_en = 1'b1;
        fill_rand(-4, 4);
        send_ops(1'b1);
        drain_check("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 10; t++) begin
            core_delay = int'($urandom_range(0, 6));
            fill_rand(-4, 4);
            send_ops(1'b1);
            drain_check("b2b", 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_stall();
        test_timeout();
        test_reset_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
